// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle for the multiplexed seven-segment scan controller:
// per-digit patterns and scan controls in, registered cathode/anode drive out.
interface seg_scan_ctrl_if;
    logic [7:0] seg_in_0;
    logic [7:0] seg_in_1;
    logic [7:0] seg_in_2;
    logic [7:0] seg_in_3;
    logic [3:0] digit_en;
    logic [3:0] brightness;
    logic [7:0] seg_out;
    logic [3:0] anode;
    logic       frame_done;

    modport master (
        output seg_in_0, seg_in_1, seg_in_2, seg_in_3, digit_en, brightness,
        input  seg_out, anode, frame_done
    );

    modport slave (
        input  seg_in_0, seg_in_1, seg_in_2, seg_in_3, digit_en, brightness,
        output seg_out, anode, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner: each enabled digit gets a slot
// made of a blanking phase followed by a PWM-dimmed display phase.
module seg_scan_ctrl #(
    parameter int unsigned SLOT_CYCLES  = 64,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
    localparam logic [15:0] SLOT_LAST  = 16'(SLOT_CYCLES - 1);

    state_t      state, state_nx;
    logic [1:0]  cur_digit, cur_digit_nx;
    logic [15:0] slot_cnt, slot_cnt_nx;
    logic [3:0]  pwm_cnt, pwm_cnt_nx;
    logic [7:0]  slot_reg, slot_reg_nx;
    logic [7:0]  seg_q, seg_nx;
    logic [3:0]  anode_q, anode_nx;
    logic        frame_q, frame_nx;

    logic [1:0]  target;
    logic [7:0]  seg_sel;
    logic        en_any;

    // First enabled digit after 'from', wrapping; returns 'from' itself if it is the only one.
    function automatic logic [1:0] next_digit(input logic [1:0] from, input logic [3:0] en);
        logic [1:0] idx;
        next_digit = from;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (en[idx]) next_digit = idx;
        end
    endfunction

    assign en_any = |bus.digit_en;
    // Searching from digit 3 yields the lowest enabled digit when leaving IDLE.
    assign target = (state == IDLE) ? next_digit(2'd3, bus.digit_en)
                                    : next_digit(cur_digit, bus.digit_en);

    always_comb begin
        case (target)
            2'd0:    seg_sel = bus.seg_in_0;
            2'd1:    seg_sel = bus.seg_in_1;
            2'd2:    seg_sel = bus.seg_in_2;
            default: seg_sel = bus.seg_in_3;
        endcase
    end

    always_comb begin
        state_nx     = state;
        cur_digit_nx = cur_digit;
        slot_cnt_nx  = slot_cnt;
        pwm_cnt_nx   = pwm_cnt;
        slot_reg_nx  = slot_reg;
        frame_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (en_any) begin
                    state_nx     = BLANK;
                    cur_digit_nx = target;
                    slot_cnt_nx  = '0;
                    slot_reg_nx  = seg_sel;
                end
            end
            BLANK: begin
                if (!en_any) begin
                    state_nx    = IDLE;
                    slot_cnt_nx = '0;
                    pwm_cnt_nx  = '0;
                end else if (slot_cnt == BLANK_LAST) begin
                    state_nx    = SHOW;
                    slot_cnt_nx = slot_cnt + 16'd1;
                    pwm_cnt_nx  = '0;
                end else begin
                    slot_cnt_nx = slot_cnt + 16'd1;
                end
            end
            SHOW: begin
                if (!en_any) begin
                    state_nx    = IDLE;
                    slot_cnt_nx = '0;
                    pwm_cnt_nx  = '0;
                end else if (slot_cnt == SLOT_LAST) begin
                    // Moving to a digit at or below the current one closes a frame.
                    state_nx     = BLANK;
                    cur_digit_nx = target;
                    slot_cnt_nx  = '0;
                    slot_reg_nx  = seg_sel;
                    frame_nx     = (target <= cur_digit);
                end else begin
                    slot_cnt_nx = slot_cnt + 16'd1;
                    pwm_cnt_nx  = pwm_cnt + 4'd1;
                end
            end
            default: begin
                state_nx    = IDLE;
                slot_cnt_nx = '0;
                pwm_cnt_nx  = '0;
            end
        endcase

        // Outputs are registered from the post-edge state so they line up with the FSM.
        anode_nx = 4'b1111;
        seg_nx   = 8'hFF;
        if (state_nx == SHOW) begin
            seg_nx = slot_reg_nx;
            if ((pwm_cnt_nx < bus.brightness) && bus.digit_en[cur_digit_nx])
                anode_nx[cur_digit_nx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_digit <= '0;
            slot_cnt  <= '0;
            pwm_cnt   <= '0;
            slot_reg  <= 8'hFF;
            seg_q     <= 8'hFF;
            anode_q   <= 4'b1111;
            frame_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            cur_digit <= cur_digit_nx;
            slot_cnt  <= slot_cnt_nx;
            pwm_cnt   <= pwm_cnt_nx;
            slot_reg  <= slot_reg_nx;
            seg_q     <= seg_nx;
            anode_q   <= anode_nx;
            frame_q   <= frame_nx;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.anode      = anode_q;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table of steady-state scan scenarios, hand-written
// corner sequences and random stimulus, all checked against a slot-position model.
module tb_seg_scan_ctrl;
    localparam int SLOT  = 64;
    localparam int BLANK = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: whether a scan is running, position inside the current slot, digit, latched pattern.
    bit         m_active;
    int         m_pos;
    int         m_digit;
    logic [7:0] m_pat;
    logic [3:0] exp_anode;
    logic [7:0] exp_seg;
    logic       exp_fd;

    int         frames;
    int         low_cycles;
    logic [3:0] low_mask;

    typedef struct {
        logic [3:0] en;
        logic [3:0] br;
        int         edges;
        int         exp_frames;
        int         exp_low;
        logic [3:0] exp_mask;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0:       return bus.seg_in_0;
            1:       return bus.seg_in_1;
            2:       return bus.seg_in_2;
            default: return bus.seg_in_3;
        endcase
    endfunction

    function automatic int next_on(input int d, input logic [3:0] en);
        for (int k = 1; k <= 4; k++)
            if (en[(d + k) % 4]) return (d + k) % 4;
        return d;
    endfunction

    task automatic model_blank();
        m_active  = 1'b0;
        exp_anode = 4'hF;
        exp_seg   = 8'hFF;
        exp_fd    = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] en;
        int         nd;
        en     = bus.digit_en;
        exp_fd = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (en != 0) begin
                m_active = 1'b1;
                m_digit  = next_on(3, en);
                m_pos    = 0;
                m_pat    = seg_of(m_digit);
            end
        end else if (en == 0) begin
            m_active = 1'b0;
        end else begin
            m_pos++;
            if (m_pos == SLOT) begin
                nd      = next_on(m_digit, en);
                exp_fd  = (nd <= m_digit);
                m_digit = nd;
                m_pos   = 0;
                m_pat   = seg_of(nd);
            end
        end
        exp_anode = 4'hF;
        exp_seg   = 8'hFF;
        if (m_active && m_pos >= BLANK) begin
            exp_seg = m_pat;
            if (((m_pos - BLANK) % 16) < int'(bus.brightness) && en[m_digit])
                exp_anode[m_digit] = 1'b0;
        end
    endtask

    task automatic compare_outputs();
        chk("anode", {28'd0, bus.anode}, {28'd0, exp_anode});
        chk("seg_out", {24'd0, bus.seg_out}, {24'd0, exp_seg});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, exp_fd});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
        if (bus.frame_done) frames++;
        if (bus.anode != 4'hF) begin
            low_cycles++;
            low_mask = low_mask | ~bus.anode;
        end
    endtask

    // Asserts reset away from the clock edge, checks outputs blank at once, then releases.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_blank();
        compare_outputs();
        repeat (2) step();
        rst_n = 1'b1;
        frames     = 0;
        low_cycles = 0;
        low_mask   = 4'h0;
    endtask

    task automatic default_inputs(input logic [3:0] en, input logic [3:0] br);
        bus.seg_in_0   = 8'hC0;
        bus.seg_in_1   = 8'hC1;
        bus.seg_in_2   = 8'hC2;
        bus.seg_in_3   = 8'hC3;
        bus.digit_en   = en;
        bus.brightness = br;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        default_inputs(4'h0, 4'h0);
        model_blank();
        #1 rst_n = 1'b0;
        #1 compare_outputs();

        tbl[0] = '{en: 4'hF, br: 4'd15, edges: 1025, exp_frames: 4, exp_low: 912, exp_mask: 4'hF};
        tbl[1] = '{en: 4'h5, br: 4'd15, edges: 513,  exp_frames: 4, exp_low: 456, exp_mask: 4'h5};
        tbl[2] = '{en: 4'hF, br: 4'd0,  edges: 1025, exp_frames: 4, exp_low: 0,   exp_mask: 4'h0};
        tbl[3] = '{en: 4'h1, br: 4'd8,  edges: 257,  exp_frames: 4, exp_low: 128, exp_mask: 4'h1};
        tbl[4] = '{en: 4'h8, br: 4'd1,  edges: 257,  exp_frames: 4, exp_low: 16,  exp_mask: 4'h8};
        tbl[5] = '{en: 4'hA, br: 4'd4,  edges: 513,  exp_frames: 4, exp_low: 128, exp_mask: 4'hA};

        for (int i = 0; i < 6; i++) begin
            default_inputs(tbl[i].en, tbl[i].br);
            do_reset();
            repeat (tbl[i].edges) step();
            chk($sformatf("tbl%0d_frames", i), frames, tbl[i].exp_frames);
            chk($sformatf("tbl%0d_low_cycles", i), low_cycles, tbl[i].exp_low);
            chk($sformatf("tbl%0d_low_mask", i), {28'd0, low_mask}, {28'd0, tbl[i].exp_mask});
        end

        // Pattern change mid-slot stays hidden until the next slot of that digit.
        default_inputs(4'hF, 4'd15);
        bus.seg_in_1 = 8'hF9;
        do_reset();
        repeat (79) step();
        bus.seg_in_1 = 8'hA4;
        repeat (48) step();
        chk("latched_seg_hold", {24'd0, bus.seg_out}, 32'hF9);
        chk("latched_anode", {28'd0, bus.anode}, 32'hD);
        repeat (203) step();
        chk("latched_seg_new", {24'd0, bus.seg_out}, 32'hA4);

        // All digits disabled at SHOW cycle 20, then digit 1 restored.
        default_inputs(4'hF, 4'd15);
        do_reset();
        repeat (25) step();
        bus.digit_en = 4'h0;
        step();
        chk("abandon_anode", {28'd0, bus.anode}, 32'hF);
        chk("abandon_seg", {24'd0, bus.seg_out}, 32'hFF);
        chk("abandon_fd", {31'd0, bus.frame_done}, 32'h0);
        bus.digit_en = 4'b0010;
        frames = 0;
        step();
        chk("restore_blank", {28'd0, bus.anode}, 32'hF);
        repeat (4) step();
        chk("restore_anode", {28'd0, bus.anode}, 32'hD);
        chk("restore_seg", {24'd0, bus.seg_out}, 32'hC1);
        chk("restore_no_frame", frames, 0);

        // Current digit disabled mid-slot: anode drops at once, slot keeps its length.
        default_inputs(4'hF, 4'd15);
        do_reset();
        repeat (10) step();
        chk("middis_before", {28'd0, bus.anode}, 32'hE);
        bus.digit_en = 4'hE;
        step();
        chk("middis_after", {28'd0, bus.anode}, 32'hF);
        repeat (58) step();
        chk("middis_next_slot", {28'd0, bus.anode}, 32'hD);

        // Reset mid-SHOW, then restart on the lowest enabled digit with a full blank.
        default_inputs(4'hF, 4'd15);
        do_reset();
        repeat (10) step();
        chk("rst_pre_anode", {28'd0, bus.anode}, 32'hE);
        bus.digit_en = 4'b0110;
        do_reset();
        repeat (4) step();
        chk("rst_restart_blank", {28'd0, bus.anode}, 32'hF);
        step();
        chk("rst_restart_anode", {28'd0, bus.anode}, 32'hD);
        chk("rst_restart_seg", {24'd0, bus.seg_out}, 32'hC1);

        // Random stimulus against the model.
        default_inputs(4'hF, 4'd15);
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 149) == 0) bus.digit_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) bus.brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.seg_in_0 = 8'($urandom);
                    1:       bus.seg_in_1 = 8'($urandom);
                    2:       bus.seg_in_2 = 8'($urandom);
                    default: bus.seg_in_3 = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 1499) == 0) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
